instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the processor's decode/execute block. It holds a small program memory and a program counter (PC). It reads one 32-bit instruction word per fetch and presents it on ir_out, which feeds the execute stage's IR, using a valid/ready handshake. The execute stage can redirect the PC with a jump request at handshake time.

---
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-memory load port, control inputs and the
// instruction handshake toward the execute stage.
//   master : the fetch unit (drives ir_out/ir_valid/pc/busy/halted/instr_count)
//   slave  : the environment (drives start, pm_*, ir_ready, jump_*)
interface instr_fetch_if #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned CNT_W   = 16
);
   logic               start;
   logic               pm_we;
   logic [ADDR_W-1:0]  pm_waddr;
   logic [INSTR_W-1:0] pm_wdata;
   logic               ir_ready;
   logic               jump_en;
   logic [ADDR_W-1:0]  jump_addr;
   logic [INSTR_W-1:0] ir_out;
   logic               ir_valid;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               halted;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      input  start, pm_we, pm_waddr, pm_wdata, ir_ready, jump_en, jump_addr,
      output ir_out, ir_valid, pc, busy, halted, instr_count
   );

   modport slave (
      output start, pm_we, pm_waddr, pm_wdata, ir_ready, jump_en, jump_addr,
      input  ir_out, ir_valid, pc, busy, halted, instr_count
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program memory + PC, one word per fetch presented
// on a registered valid/ready interface to the execute stage.
// Ports:
//   clk     : system clock, rising edge
//   sys_rst : asynchronous active-high reset (memory contents are kept)
//   bus     : instr_fetch_if.master (start, pm write port, ir handshake, jump,
//             pc/busy/halted/instr_count status)
// Optional: define FETCH_HALT_DETECT_EN to stop in a HALTED state after
// handshaking an instruction whose opcode is 5'b11111.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic          clk,
   input  logic          sys_rst,
   instr_fetch_if.master bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StValid
`ifdef FETCH_HALT_DETECT_EN
      , StHalted
`endif
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [INSTR_W-1:0] rdata;
   logic               mem_we;
   logic               handshake;

   assign mem_we    = (state_q == StIdle) && bus.pm_we;
   assign handshake = (state_q == StValid) && valid_q && bus.ir_ready;

`ifdef FETCH_HALT_DETECT_EN
   logic is_halt;
   assign is_halt = (ir_q[INSTR_W-1 -: 5] == 5'b11111);
`endif

   // Program memory is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[bus.pm_waddr] <= bus.pm_wdata;
      end
      if (state_q == StFetch) begin
         rdata <= mem[pc_q];
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         ir_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StLoad;
         end
         StLoad: begin
            ir_d    = rdata;
            valid_d = 1'b1;
            state_d = StValid;
         end
         StValid: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (!(&cnt_q)) begin
                  cnt_d = cnt_q + 1'b1;
               end
`ifdef FETCH_HALT_DETECT_EN
               if (is_halt) begin
                  // PC stays on the HALT word; resume steps past it.
                  state_d = StHalted;
               end else begin
                  pc_d    = bus.jump_en ? bus.jump_addr : pc_q + 1'b1;
                  state_d = StFetch;
               end
`else
               pc_d    = bus.jump_en ? bus.jump_addr : pc_q + 1'b1;
               state_d = StFetch;
`endif
            end
         end
`ifdef FETCH_HALT_DETECT_EN
         StHalted: begin
            if (bus.start) begin
               pc_d    = pc_q + 1'b1;
               state_d = StFetch;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.ir_out      = ir_q;
   assign bus.ir_valid    = valid_q;
   assign bus.pc          = pc_q;
   assign bus.instr_count = cnt_q;
   assign bus.busy        = (state_q == StFetch) || (state_q == StLoad) || (state_q == StValid);
`ifdef FETCH_HALT_DETECT_EN
   assign bus.halted      = (state_q == StHalted);
`else
   assign bus.halted      = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level model of the
// fetch stream (memory image, PC, count, edges-until-valid) checked every
// cycle, a table of handshakes with fixed expected words, and random traffic.
module tb_instr_fetch_unit;
`ifdef FETCH_HALT_DETECT_EN
   localparam bit HaltEn = 1'b1;
`else
   localparam bit HaltEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_if #(.ADDR_W(8), .INSTR_W(32), .CNT_W(16)) bus ();

   instr_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .CNT_W(16)) dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] mem_m [256];
   logic [7:0]  pc_m;
   int          cnt_m;
   bit          active;    // fetching or presenting
   bit          halted_m;
   int          k;         // edges still to go before ir_valid

   typedef struct {
      logic        jen;
      logic [7:0]  ja;
      logic [7:0]  exp_pc;
      logic [31:0] exp_ir;
      int          exp_cnt;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] word;
   } prog_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, check outputs at the negedge.
   task automatic tick(input logic rdy, input logic jen, input logic [7:0] ja, input logic st,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd);
      bit hs;
      bus.ir_ready = rdy;  bus.jump_en = jen;  bus.jump_addr = ja;  bus.start = st;
      bus.pm_we = we;      bus.pm_waddr = wa;  bus.pm_wdata = wd;
      hs = active && (k == 0) && rdy;
      @(posedge clk);
      if (we && !active && !halted_m) mem_m[wa] = wd;
      if (hs) begin
         if (cnt_m < 65535) cnt_m++;
         if (HaltEn && mem_m[pc_m][31:27] == 5'h1f) begin
            halted_m = 1'b1;
            active   = 1'b0;
         end else begin
            pc_m = jen ? ja : pc_m + 8'd1;
            k    = 2;
         end
      end else if (st && !active) begin
         if (halted_m) begin
            pc_m     = pc_m + 8'd1;
            halted_m = 1'b0;
         end
         active = 1'b1;
         k      = 2;
      end else if (active && k > 0) begin
         k--;
      end
      @(negedge clk);
      check("ir_valid", {63'd0, bus.ir_valid}, {63'd0, active && k == 0});
      check("pc", {56'd0, bus.pc}, {56'd0, pc_m});
      check("instr_count", {48'd0, bus.instr_count}, 64'(cnt_m));
      check("busy", {63'd0, bus.busy}, {63'd0, active});
      check("halted", {63'd0, bus.halted}, {63'd0, halted_m});
      if (active && k == 0) check("ir_out", {32'd0, bus.ir_out}, {32'd0, mem_m[pc_m]});
   endtask

   task automatic run(input logic rdy, input logic jen, input logic [7:0] ja);
      tick(rdy, jen, ja, 1'b0, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic start_pulse();
      tick(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic write_word(input logic [7:0] a, input logic [31:0] d);
      tick(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, a, d);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 8 && !bus.ir_valid; i++) run(1'b0, 1'b0, 8'd0);
      check("valid_timeout", {63'd0, bus.ir_valid}, 64'd1);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear with no edge.
   task automatic do_reset();
      bus.start = 1'b0;  bus.pm_we = 1'b0;  bus.ir_ready = 1'b0;  bus.jump_en = 1'b0;
      #2 sys_rst = 1'b1;
      #1;
      check("rst_ir_out", {32'd0, bus.ir_out}, 64'd0);
      check("rst_ir_valid", {63'd0, bus.ir_valid}, 64'd0);
      check("rst_pc", {56'd0, bus.pc}, 64'd0);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_halted", {63'd0, bus.halted}, 64'd0);
      check("rst_count", {48'd0, bus.instr_count}, 64'd0);
      pc_m = 8'd0;  cnt_m = 0;  active = 1'b0;  halted_m = 1'b0;  k = 0;
      @(negedge clk);
      sys_rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:27] == 5'h1f) w[31] = 1'b0;
      return w;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      prog_t prog[7];
      vec_t  vecs[7];

      prog[0] = '{8'h00, 32'h0840_0005};
      prog[1] = '{8'h01, 32'h1084_0003};
      prog[2] = '{8'h02, 32'h10C6_0001};
      prog[3] = '{8'h40, 32'h2222_0040};
      prog[4] = '{8'h41, 32'h3333_0041};
      prog[5] = '{8'hFF, 32'h4444_00FF};
      prog[6] = '{8'h10, 32'h5555_0010};

      vecs[0] = '{1'b0, 8'h00, 8'h00, 32'h0840_0005, 1};
      vecs[1] = '{1'b0, 8'h00, 8'h01, 32'h1084_0003, 2};
      vecs[2] = '{1'b1, 8'h40, 8'h02, 32'h10C6_0001, 3};
      vecs[3] = '{1'b1, 8'hFF, 8'h40, 32'h2222_0040, 4};
      vecs[4] = '{1'b0, 8'h00, 8'hFF, 32'h4444_00FF, 5};
      vecs[5] = '{1'b1, 8'h10, 8'h00, 32'h0840_0005, 6};
      vecs[6] = '{1'b0, 8'h00, 8'h10, 32'h5555_0010, 7};

      bus.start = 1'b0;  bus.pm_we = 1'b0;  bus.pm_waddr = '0;  bus.pm_wdata = '0;
      bus.ir_ready = 1'b0;  bus.jump_en = 1'b0;  bus.jump_addr = '0;
      for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
      @(negedge clk);
      do_reset();

      // Load: random background, then the fixed program.
      for (int i = 0; i < 256; i++) write_word(8'(i), rand_word());
      for (int i = 0; i < 7; i++) write_word(prog[i].addr, prog[i].word);

      // Streaming with ready held high: valid one cycle in three.
      start_pulse();
      for (int i = 0; i < 9; i++) run(1'b1, 1'b0, 8'd0);
      check("stream_count", {48'd0, bus.instr_count}, 64'd3);

      // Backpressure, jump ignored without handshake, write ignored in VALID.
      do_reset();
      start_pulse();
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         if (i == 4) tick(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF);
         else run(1'b0, 1'b1, 8'($urandom));
      end
      check("bp_ir_out", {32'd0, bus.ir_out}, 64'h0840_0005);
      check("bp_pc", {56'd0, bus.pc}, 64'd0);
      check("bp_valid", {63'd0, bus.ir_valid}, 64'd1);
      run(1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 5; i++) run(1'b0, 1'b0, 8'd0);
      check("bp_count", {48'd0, bus.instr_count}, 64'd1);

      // Handshake table: jumps, wrap at 0xFF, gated write read back.
      do_reset();
      start_pulse();
      for (int i = 0; i < 7; i++) begin
         wait_valid();
         check("tbl_pc", {56'd0, bus.pc}, {56'd0, vecs[i].exp_pc});
         check("tbl_ir", {32'd0, bus.ir_out}, {32'd0, vecs[i].exp_ir});
         run(1'b1, vecs[i].jen, vecs[i].ja);
         check("tbl_count", {48'd0, bus.instr_count}, 64'(vecs[i].exp_cnt));
      end

      // Reset during LOAD, then refetch from 0.
      do_reset();
      start_pulse();
      run(1'b0, 1'b0, 8'd0);
      do_reset();
      start_pulse();
      wait_valid();
      check("rst_refetch", {32'd0, bus.ir_out}, 64'h0840_0005);

      // HALT opcode at address 3.
      do_reset();
      write_word(8'h03, 32'hF800_0000);
      start_pulse();
      for (int i = 0; i < 12; i++) run(1'b1, 1'b0, 8'd0);
      check("halt_count", {48'd0, bus.instr_count}, 64'd4);
`ifdef FETCH_HALT_DETECT_EN
      check("halt_flag", {63'd0, bus.halted}, 64'd1);
      check("halt_pc", {56'd0, bus.pc}, 64'd3);
      for (int i = 0; i < 4; i++) run(1'b1, 1'b0, 8'd0);
      start_pulse();
      check("resume_pc", {56'd0, bus.pc}, 64'd4);
      check("resume_halted", {63'd0, bus.halted}, 64'd0);
`else
      check("pass_pc", {56'd0, bus.pc}, 64'd4);
      check("pass_halted", {63'd0, bus.halted}, 64'd0);
`endif
      wait_valid();

      // Random traffic.
      do_reset();
      write_word(8'h03, rand_word());
      start_pulse();
      for (int i = 0; i < 3000; i++) begin
         tick(1'($urandom), ($urandom % 4) == 0, 8'($urandom), ($urandom % 16) == 0,
              ($urandom % 16) == 0, 8'($urandom), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
